// File: rtl/hdecim2_sink_if.sv
// Pixel stream bundle for hdecim2_sink: undecimated input samples in, tagged decimated pixels out.
// The sink module takes the slave view; the driver/consumer side takes the master view.
interface hdecim2_sink_if;
    logic [15:0] hin;
    logic        hin_valid;
    logic [15:0] hout;
    logic        hout_valid;
    logic        hout_ready;
    logic        hout_sof;
    logic        hout_eol;
    logic        hout_eof;

    modport slave (
        input  hin, hin_valid, hout_ready,
        output hout, hout_valid, hout_sof, hout_eol, hout_eof
    );

    modport master (
        output hin, hin_valid, hout_ready,
        input  hout, hout_valid, hout_sof, hout_eol, hout_eof
    );
endinterface

// File: rtl/hdecim2_sink.sv
// Drops convolver warm-up samples, decimates the raster by 2 in both axes and queues
// tagged pixels in a small FWFT FIFO; overruns drop the sample and set a sticky flag.
module hdecim2_sink #(
    parameter logic [15:0] HIM_LEN    = 16'd520,
    parameter logic [15:0] HIM_HGT    = 16'd520,
    parameter logic [15:0] LAT        = 16'd523,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          hres_n,
    input  logic          hclrbuffer,
    hdecim2_sink_if.slave bus,
    output logic          hovf
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [15:0] LAST_COL      = HIM_LEN - 16'd1;
    localparam logic [15:0] LAST_ROW      = HIM_HGT - 16'd1;
    localparam logic [15:0] LAST_EVEN_COL = LAST_COL & 16'hFFFE;
    localparam logic [15:0] LAST_EVEN_ROW = LAST_ROW & 16'hFFFE;

    typedef enum logic [1:0] {WARM, ACTIVE, DONE} state_e;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic        eof;
        logic [15:0] data;
    } entry_t;

    state_e          state_q, state_d;
    logic [15:0]     warm_q, warm_d;
    logic [15:0]     col_q, col_d;
    logic [15:0]     row_q, row_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            hovf_q, hovf_d;
    entry_t          mem_q [FIFO_DEPTH];

    logic   keep;
    logic   pop;
    logic   full;
    logic   wr_en;
    entry_t wr_entry;
    entry_t head;

    // Raster walk: warm-up count, then column/row position of each valid sample.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d       = state_q;
        warm_d        = warm_q;
        col_d         = col_q;
        row_d         = row_q;
        keep          = 1'b0;
        wr_entry      = '0;
        wr_entry.data = bus.hin;

        if (hclrbuffer) begin
            state_d = WARM;
            warm_d  = '0;
            col_d   = '0;
            row_d   = '0;
        end else if (bus.hin_valid) begin
            case (state_q)
                WARM: begin
                    if (warm_q == LAT - 16'd1) begin
                        state_d = ACTIVE;
                        warm_d  = '0;
                        col_d   = '0;
                        row_d   = '0;
                    end else begin
                        warm_d = warm_q + 16'd1;
                    end
                end
                ACTIVE: begin
                    keep         = !col_q[0] && !row_q[0];
                    wr_entry.sof = (col_q == 16'd0) && (row_q == 16'd0);
                    wr_entry.eol = (col_q == LAST_EVEN_COL);
                    wr_entry.eof = (col_q == LAST_EVEN_COL) && (row_q == LAST_EVEN_ROW);
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) state_d = DONE;
                        else                   row_d   = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO bookkeeping; a pop frees a slot for a push in the same cycle.
    always_comb begin
        pop      = bus.hout_valid && bus.hout_ready;
        full     = (count_q == CW'(FIFO_DEPTH));
        wr_en    = 1'b0;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hovf_d   = hovf_q;

        if (hclrbuffer) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            hovf_d   = 1'b0;
        end else begin
            wr_en = keep && (!full || pop);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            count_d = count_q + CW'(wr_en) - CW'(pop);
            if (keep && !wr_en) hovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge hres_n) begin
        if (!hres_n) begin
            state_q  <= WARM;
            warm_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            warm_q   <= warm_d;
            col_q    <= col_d;
            row_q    <= row_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hovf_q   <= hovf_d;
        end
    end

    // NOTE: storage is not reset; count_q gates every read, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head           = mem_q[rd_ptr_q];
    assign bus.hout_valid = (count_q != '0);
    assign bus.hout       = bus.hout_valid ? head.data : 16'd0;
    assign bus.hout_sof   = bus.hout_valid && head.sof;
    assign bus.hout_eol   = bus.hout_valid && head.eol;
    assign bus.hout_eof   = bus.hout_valid && head.eof;
    assign hovf           = hovf_q;
endmodule

// File: tb/tb_hdecim2_sink.sv
// Bench for hdecim2_sink: directed ramps plus random traffic, checked every cycle against a
// queue-based model derived from the sample index and the raster geometry.
module tb_hdecim2_sink;
    localparam int LEN   = 8;
    localparam int HGT   = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int LEC   = (LEN - 1) - ((LEN - 1) % 2);
    localparam int LER   = (HGT - 1) - ((HGT - 1) % 2);

    logic clk;
    logic hres_n;
    logic hclrbuffer;
    logic hovf;
    hdecim2_sink_if bus ();

    hdecim2_sink #(
        .HIM_LEN    (16'(LEN)),
        .HIM_HGT    (16'(HGT)),
        .LAT        (16'(LAT)),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .hres_n     (hres_n),
        .hclrbuffer (hclrbuffer),
        .bus        (bus.slave),
        .hovf       (hovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [18:0] exp_q [$];
    logic [15:0] got_q [$];
    logic [15:0] seq_a [$];
    logic [15:0] seq_b [$];
    bit          m_ovf;
    int          m_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_ovf = 1'b0;
        m_n   = 0;
    endtask

    // Compare outputs at the falling edge, drive inputs, then advance the model at the rising edge.
    task automatic step(input bit v, input logic [15:0] d, input bit rdy, input bit clr);
        int  p, r, c, sz;
        bit  popped;
        check("hout_valid", 32'(bus.hout_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0)
            check("head", {bus.hout_sof, bus.hout_eol, bus.hout_eof, bus.hout}, 32'(exp_q[0]));
        else
            check("idle_out", {bus.hout_sof, bus.hout_eol, bus.hout_eof, bus.hout}, 32'd0);
        check("hovf", 32'(hovf), 32'(m_ovf));

        bus.hin_valid  = v;
        bus.hin        = d;
        bus.hout_ready = rdy;
        hclrbuffer     = clr;
        @(posedge clk);

        sz     = exp_q.size();
        popped = (sz != 0) && rdy;
        if (popped) begin
            got_q.push_back(exp_q[0][15:0]);
            void'(exp_q.pop_front());
        end
        if (clr) begin
            model_clear();
        end else if (v && m_n < LAT + LEN * HGT) begin
            if (m_n >= LAT) begin
                p = m_n - LAT;
                r = p / LEN;
                c = p % LEN;
                if (r % 2 == 0 && c % 2 == 0) begin
                    if (sz < DEPTH || popped)
                        exp_q.push_back({p == 0, c == LEC, c == LEC && r == LER, d});
                    else
                        m_ovf = 1'b1;
                end
            end
            m_n++;
        end
        @(negedge clk);
    endtask

    task automatic ramp(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, 16'(i), rdy, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b1, 1'b0);
    endtask

    task automatic clear_pulse();
        step(1'b0, 16'd0, 1'b0, 1'b1);
        got_q.delete();
    endtask

    task automatic check_seq(input string tag, input logic [15:0] exp [$]);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            check(tag, 32'(got_q[i]), 32'(exp[i]));
    endtask

    initial begin
        hres_n         = 1'b0;
        hclrbuffer     = 1'b0;
        bus.hin        = '0;
        bus.hin_valid  = 1'b0;
        bus.hout_ready = 1'b0;
        model_clear();
        seq_a = '{16'd3, 16'd5, 16'd7, 16'd9, 16'd19, 16'd21, 16'd23, 16'd25};
        seq_b = '{16'd3, 16'd5, 16'd7, 16'd9, 16'd21, 16'd23, 16'd25};

        #1;
        check("rst_valid", 32'(bus.hout_valid), 32'd0);
        check("rst_hovf", 32'(hovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        hres_n = 1'b1;

        // 1: ramp with ready held high; trailing samples fall into DONE
        got_q.delete();
        ramp(40, 1'b1);
        drain(6);
        check_seq("s1_seq", seq_a);

        // 2: consumer stalled until just after sample 19 overruns the FIFO
        clear_pulse();
        for (int i = 0; i < 40; i++) step(1'b1, 16'(i), i > 19, 1'b0);
        check("s2_ovf", 32'(hovf), 32'd1);
        drain(6);
        check_seq("s2_seq", seq_b);

        // 3: hin_valid toggling every cycle
        clear_pulse();
        for (int i = 0; i < 80; i++) step(i % 2 == 0, 16'(i / 2), 1'b1, 1'b0);
        drain(6);
        check_seq("s3_seq", seq_a);

        // 4: clear with a full FIFO and hovf set, then restart
        clear_pulse();
        ramp(21, 1'b0);
        check("s4_pre_ovf", 32'(hovf), 32'd1);
        clear_pulse();
        check("s4_valid", 32'(bus.hout_valid), 32'd0);
        check("s4_hovf", 32'(hovf), 32'd0);
        ramp(40, 1'b1);
        drain(6);
        check_seq("s4_seq", seq_a);

        // 5: asynchronous reset between clock edges
        clear_pulse();
        ramp(21, 1'b0);
        #2 hres_n = 1'b0;
        #1;
        check("s5_valid", 32'(bus.hout_valid), 32'd0);
        check("s5_hout", 32'(bus.hout), 32'd0);
        check("s5_flags", {bus.hout_sof, bus.hout_eol, bus.hout_eof}, 32'd0);
        check("s5_hovf", 32'(hovf), 32'd0);
        model_clear();
        got_q.delete();
        @(negedge clk);
        hres_n = 1'b1;
        ramp(40, 1'b1);
        drain(6);
        check_seq("s5_seq", seq_a);

        // 6: full FIFO, pop and kept sample in the same cycle
        clear_pulse();
        ramp(19, 1'b0);
        step(1'b1, 16'd19, 1'b1, 1'b0);
        got_q.delete();
        step(1'b0, 16'd0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b0, 1'b0);
        check("s6_hovf", 32'(hovf), 32'd0);
        drain(6);
        check_seq("s6_seq", '{16'd5, 16'd7, 16'd9, 16'd19});

        // 7: random traffic, backpressure and occasional restarts
        clear_pulse();
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 300) == 0);
        drain(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
